// File: rtl/pll_drp_pkg.sv
// Shared types and field layout for the PLL DRP reconfiguration sequencer.
// A stored entry is {addr[6:0], mask[15:0], data[15:0]}.
package pll_drp_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK,
      WAIT_SEN,
      READ,
      WAIT_R,
      WRITE,
      WAIT_W,
      RELEASE
   } state_t;

   localparam int ADDR_W   = 7;
   localparam int DATA_W   = 16;
   localparam int ENTRY_W  = 39;
   localparam int DATA_LSB = 0;
   localparam int MASK_LSB = 16;
   localparam int ADDR_LSB = 32;

endpackage

// File: rtl/pll_drp_rom.sv
// Combinational lookup of one reconfiguration entry from the two stored sets,
// split into DRP address, keep-mask and new data.
module pll_drp_rom
   import pll_drp_pkg::*;
#(
   parameter int                           ENTRIES  = 4,
   parameter int                           IDX_W    = 2,
   parameter logic [ENTRIES*ENTRY_W-1:0]   SET0_ROM = '0,
   parameter logic [ENTRIES*ENTRY_W-1:0]   SET1_ROM = '0
) (
   input  logic              sel,
   input  logic [IDX_W-1:0]  idx,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] mask,
   output logic [DATA_W-1:0] data
);

   logic [ENTRY_W-1:0] entry;

   // Index compare per entry keeps every part-select constant, so non-power-of-two
   // ENTRIES never reads past the end of the ROM.
   always_comb begin
      entry = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (idx == IDX_W'(i)) begin
            entry = sel ? SET1_ROM[i*ENTRY_W +: ENTRY_W] : SET0_ROM[i*ENTRY_W +: ENTRY_W];
         end
      end
   end

   assign addr = entry[ADDR_LSB +: ADDR_W];
   assign mask = entry[MASK_LSB +: DATA_W];
   assign data = entry[DATA_LSB +: DATA_W];

endmodule

// File: rtl/pll_drp_sequencer.sv
// DRP master: holds the PLL in reset, read-modify-writes ENTRIES registers from
// the selected set, releases reset and reports completion once relocked.
module pll_drp_sequencer
   import pll_drp_pkg::*;
#(
   parameter int                           ENTRIES  = 4,
   parameter logic [ENTRIES*ENTRY_W-1:0]   SET0_ROM = '0,
   parameter logic [ENTRIES*ENTRY_W-1:0]   SET1_ROM = '0,
   parameter int                           TIMEOUT  = 255
) (
   input  logic              DCLK,
   input  logic              RST,
   input  logic              SSTEP,
   input  logic              SADDR,
   output logic              SRDY,
   output logic              ERR,
   output logic [ADDR_W-1:0] DADDR,
   output logic              DEN,
   output logic              DWE,
   output logic [DATA_W-1:0] DI,
   input  logic [DATA_W-1:0] DO,
   input  logic              DRDY,
   input  logic              LOCKED,
   output logic              PLL_RST
);

   localparam int         IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam logic [7:0] TO_V  = 8'(TIMEOUT);

   state_t             state, state_d;
   logic [IDX_W-1:0]   idx, idx_d;
   logic               sel, sel_d;
   logic               busy, busy_d;
   logic [7:0]         cnt, cnt_d, cnt_inc;
   logic               srdy_d, err_d, den_d, dwe_d, pll_rst_d;
   logic [ADDR_W-1:0]  daddr_d;
   logic [DATA_W-1:0]  di_d;
   logic [ADDR_W-1:0]  e_addr;
   logic [DATA_W-1:0]  e_mask, e_data;

   // Mask bit 1 keeps the bit read back from the PLL.
   function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] rd,
                                                   input logic [DATA_W-1:0] mask,
                                                   input logic [DATA_W-1:0] data);
      return (rd & mask) | (data & ~mask);
   endfunction

   // Looked up with next-cycle select/index so registered strobes carry the right entry.
   pll_drp_rom #(
      .ENTRIES  (ENTRIES),
      .IDX_W    (IDX_W),
      .SET0_ROM (SET0_ROM),
      .SET1_ROM (SET1_ROM)
   ) u_rom (
      .sel  (sel_d),
      .idx  (idx_d),
      .addr (e_addr),
      .mask (e_mask),
      .data (e_data)
   );

   assign cnt_inc = cnt + 8'd1;

   always_comb begin
      state_d   = state;
      idx_d     = idx;
      sel_d     = sel;
      busy_d    = busy;
      cnt_d     = cnt;
      srdy_d    = 1'b0;
      err_d     = ERR;
      pll_rst_d = PLL_RST;
      daddr_d   = DADDR;
      di_d      = DI;
      den_d     = 1'b0;
      dwe_d     = 1'b0;
      case (state)
         WAIT_LOCK: begin
            if (LOCKED) begin
               srdy_d  = busy;
               busy_d  = 1'b0;
               state_d = WAIT_SEN;
            end
         end
         WAIT_SEN: begin
            if (SSTEP) begin
               sel_d     = SADDR;
               idx_d     = '0;
               pll_rst_d = 1'b1;
               busy_d    = 1'b1;
               err_d     = 1'b0;
               state_d   = READ;
            end
         end
         READ: begin
            cnt_d   = '0;
            state_d = WAIT_R;
         end
         WAIT_R: begin
            if (DRDY) begin
               di_d    = rmw_merge(DO, e_mask, e_data);
               state_d = WRITE;
            end else if (cnt_inc == TO_V) begin
               err_d   = 1'b1;
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WRITE: begin
            cnt_d   = '0;
            state_d = WAIT_W;
         end
         WAIT_W: begin
            if (DRDY) begin
               if (idx == IDX_W'(ENTRIES - 1)) begin
                  state_d = RELEASE;
               end else begin
                  idx_d   = idx + IDX_W'(1);
                  state_d = READ;
               end
            end else if (cnt_inc == TO_V) begin
               err_d   = 1'b1;
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         RELEASE: state_d = WAIT_LOCK;
         default: state_d = WAIT_LOCK;
      endcase

      // Strobes are registered, so they are raised on entry to the strobe state.
      if (state_d == READ || state_d == WRITE) begin
         den_d   = 1'b1;
         dwe_d   = (state_d == WRITE);
         daddr_d = e_addr;
      end
      if (state_d == RELEASE) begin
         pll_rst_d = 1'b0;
      end
   end

   always_ff @(posedge DCLK) begin
      if (RST) begin
         state   <= WAIT_LOCK;
         idx     <= '0;
         sel     <= 1'b0;
         busy    <= 1'b0;
         cnt     <= '0;
         SRDY    <= 1'b0;
         ERR     <= 1'b0;
         DADDR   <= '0;
         DEN     <= 1'b0;
         DWE     <= 1'b0;
         DI      <= '0;
         PLL_RST <= 1'b0;
      end else begin
         state   <= state_d;
         idx     <= idx_d;
         sel     <= sel_d;
         busy    <= busy_d;
         cnt     <= cnt_d;
         SRDY    <= srdy_d;
         ERR     <= err_d;
         DADDR   <= daddr_d;
         DEN     <= den_d;
         DWE     <= dwe_d;
         DI      <= di_d;
         PLL_RST <= pll_rst_d;
      end
   end

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Directed bench: a one-entry instance (a) and a four-entry instance (b), each
// with a small DRP slave and PLL lock model.
module tb_pll_drp_sequencer;
   import pll_drp_pkg::*;

   localparam logic [38:0]  A_SET0 = {7'h08, 16'hF000, 16'h0183};
   localparam logic [155:0] B_SET0 = {7'h0B, 16'hFFFF, 16'h0000, 7'h0A, 16'hFFFF, 16'h0000,
                                      7'h09, 16'hFFFF, 16'h0000, 7'h08, 16'h0000, 16'h6183};
   localparam logic [155:0] B_SET1 = {7'h15, 16'hF0F0, 16'h0A0A, 7'h14, 16'h0000, 16'hBEEF,
                                      7'h09, 16'hFFFF, 16'h0000, 7'h08, 16'h00FF, 16'h1200};

   logic DCLK = 1'b0;
   logic RST  = 1'b1;
   logic lock_auto = 1'b0;
   logic lock_man  = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic        a_sstep = 1'b0, a_saddr = 1'b0, a_srdy, a_err, a_den, a_dwe, a_pll_rst, a_locked;
   logic [6:0]  a_daddr;
   logic [15:0] a_di, a_do = '0;
   logic        a_drdy = 1'b0, a_drdy_en = 1'b1, a_den_q = 1'b0;
   logic [15:0] a_rdval [0:127];
   logic [6:0]  a_laddr [0:63];
   logic        a_lwe   [0:63];
   logic [15:0] a_ldi   [0:63];
   int          a_ln = 0, a_dbl = 0, a_srdy_n = 0, a_lcnt = 0;

   logic        b_sstep = 1'b0, b_saddr = 1'b0, b_srdy, b_err, b_den, b_dwe, b_pll_rst, b_locked;
   logic [6:0]  b_daddr;
   logic [15:0] b_di, b_do = '0;
   logic        b_drdy = 1'b0, b_drdy_en = 1'b1, b_den_q = 1'b0;
   logic [15:0] b_rdval [0:127];
   logic [6:0]  b_laddr [0:63];
   logic        b_lwe   [0:63];
   logic [15:0] b_ldi   [0:63];
   int          b_ln = 0, b_dbl = 0, b_srdy_n = 0, b_lcnt = 0;

   always #5 DCLK = ~DCLK;

   assign a_locked = lock_auto ? (a_lcnt == 3 && !a_pll_rst) : lock_man;
   assign b_locked = lock_auto ? (b_lcnt == 3 && !b_pll_rst) : lock_man;

   pll_drp_sequencer #(.ENTRIES(1), .SET0_ROM(A_SET0), .SET1_ROM('0), .TIMEOUT(255)) dut_a (
      .DCLK(DCLK), .RST(RST), .SSTEP(a_sstep), .SADDR(a_saddr), .SRDY(a_srdy), .ERR(a_err),
      .DADDR(a_daddr), .DEN(a_den), .DWE(a_dwe), .DI(a_di), .DO(a_do), .DRDY(a_drdy),
      .LOCKED(a_locked), .PLL_RST(a_pll_rst));

   pll_drp_sequencer #(.ENTRIES(4), .SET0_ROM(B_SET0), .SET1_ROM(B_SET1), .TIMEOUT(255)) dut_b (
      .DCLK(DCLK), .RST(RST), .SSTEP(b_sstep), .SADDR(b_saddr), .SRDY(b_srdy), .ERR(b_err),
      .DADDR(b_daddr), .DEN(b_den), .DWE(b_dwe), .DI(b_di), .DO(b_do), .DRDY(b_drdy),
      .LOCKED(b_locked), .PLL_RST(b_pll_rst));

   // DRP slaves answer one cycle after each strobe; PLLs relock 3 cycles after reset release.
   always @(posedge DCLK) begin
      a_drdy <= 1'b0;
      if (a_den) begin
         a_drdy <= a_drdy_en;
         a_do   <= a_dwe ? 16'h0000 : a_rdval[a_daddr];
         if (a_ln < 64) begin
            a_laddr[a_ln] <= a_daddr; a_lwe[a_ln] <= a_dwe; a_ldi[a_ln] <= a_di;
         end
         a_ln <= a_ln + 1;
      end
      if (a_den && a_den_q) a_dbl <= a_dbl + 1;
      a_den_q <= a_den;
      if (a_srdy) a_srdy_n <= a_srdy_n + 1;
      if (a_pll_rst) a_lcnt <= 0; else if (a_lcnt != 3) a_lcnt <= a_lcnt + 1;
   end

   always @(posedge DCLK) begin
      b_drdy <= 1'b0;
      if (b_den) begin
         b_drdy <= b_drdy_en;
         b_do   <= b_dwe ? 16'h0000 : b_rdval[b_daddr];
         if (b_ln < 64) begin
            b_laddr[b_ln] <= b_daddr; b_lwe[b_ln] <= b_dwe; b_ldi[b_ln] <= b_di;
         end
         b_ln <= b_ln + 1;
      end
      if (b_den && b_den_q) b_dbl <= b_dbl + 1;
      b_den_q <= b_den;
      if (b_srdy) b_srdy_n <= b_srdy_n + 1;
      if (b_pll_rst) b_lcnt <= 0; else if (b_lcnt != 3) b_lcnt <= b_lcnt + 1;
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge DCLK);
         #1;
      end
   endtask

   task automatic test_reset;
      RST = 1'b1; lock_auto = 1'b0; lock_man = 1'b0;
      tick(2);
      checks++;
      if ({b_srdy, b_err, b_daddr, b_den, b_dwe, b_di, b_pll_rst} !== 28'h0) begin
         errors++; $display("FAIL reset_outputs: got %h want 0", {b_srdy, b_err, b_daddr, b_den, b_dwe, b_di, b_pll_rst});
      end
      RST = 1'b0;
      tick(3);
      checks++;
      if (dut_b.state !== WAIT_LOCK) begin
         errors++; $display("FAIL reset_wait_lock: got %0d want %0d", dut_b.state, WAIT_LOCK);
      end
      lock_man = 1'b1;
      tick(2);
      checks++;
      if (dut_b.state !== WAIT_SEN) begin
         errors++; $display("FAIL lock_to_wait_sen: got %0d want %0d", dut_b.state, WAIT_SEN);
      end
      checks++;
      if (a_srdy_n != 0 || b_srdy_n != 0) begin
         errors++; $display("FAIL reset_no_srdy: got %0d/%0d want 0/0", a_srdy_n, b_srdy_n);
      end
      lock_auto = 1'b1;
      tick(4);
   endtask

   task automatic test_single_rmw;
      int ln0 = a_ln;
      int sr0 = a_srdy_n;
      a_saddr = 1'b0; a_sstep = 1'b1;
      tick();
      a_sstep = 1'b0;
      checks++;
      if (a_pll_rst !== 1'b1) begin
         errors++; $display("FAIL single_pll_rst_on: got %b want 1", a_pll_rst);
      end
      for (int i = 0; i < 100 && a_srdy_n == sr0; i++) tick();
      checks++;
      if (a_srdy_n != sr0 + 1) begin
         errors++; $display("FAIL single_srdy: got %0d pulses want 1", a_srdy_n - sr0);
      end
      checks++;
      if (a_ln - ln0 != 2 || a_laddr[ln0] !== 7'h08 || a_lwe[ln0] !== 1'b0) begin
         errors++; $display("FAIL single_read: got n=%0d addr=%h we=%b want n=2 addr=08 we=0", a_ln - ln0, a_laddr[ln0], a_lwe[ln0]);
      end
      checks++;
      if (a_laddr[ln0+1] !== 7'h08 || a_lwe[ln0+1] !== 1'b1 || a_ldi[ln0+1] !== 16'hA183) begin
         errors++; $display("FAIL single_write: got addr=%h we=%b di=%h want 08 1 A183", a_laddr[ln0+1], a_lwe[ln0+1], a_ldi[ln0+1]);
      end
      checks++;
      if (a_pll_rst !== 1'b0) begin
         errors++; $display("FAIL single_pll_rst_off: got %b want 0", a_pll_rst);
      end
   endtask

   task automatic test_set_select;
      logic [6:0]  exp_addr [0:3] = '{7'h08, 7'h09, 7'h14, 7'h15};
      logic [15:0] exp_di   [0:3] = '{16'h1256, 16'h1111, 16'hBEEF, 16'h3A3A};
      int ln0 = b_ln;
      int sr0 = b_srdy_n;
      int db0 = b_dbl;
      b_saddr = 1'b1; b_sstep = 1'b1;
      tick();
      b_sstep = 1'b0;
      for (int i = 0; i < 100 && b_srdy_n == sr0; i++) tick();
      checks++;
      if (b_srdy_n != sr0 + 1 || b_ln - ln0 != 8) begin
         errors++; $display("FAIL set1_counts: got srdy=%0d strobes=%0d want 1 8", b_srdy_n - sr0, b_ln - ln0);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (b_laddr[ln0+2*k] !== exp_addr[k] || b_lwe[ln0+2*k] !== 1'b0 ||
             b_laddr[ln0+2*k+1] !== exp_addr[k] || b_lwe[ln0+2*k+1] !== 1'b1 ||
             b_ldi[ln0+2*k+1] !== exp_di[k]) begin
            errors++; $display("FAIL set1_entry%0d: got rd=%h wr=%h we=%b%b di=%h want %h %h 01 %h", k,
               b_laddr[ln0+2*k], b_laddr[ln0+2*k+1], b_lwe[ln0+2*k], b_lwe[ln0+2*k+1], b_ldi[ln0+2*k+1],
               exp_addr[k], exp_addr[k], exp_di[k]);
         end
      end
      checks++;
      if (b_dbl != db0) begin
         errors++; $display("FAIL den_consecutive: got %0d want 0", b_dbl - db0);
      end
   endtask

   task automatic test_timeout;
      int ln0 = b_ln;
      int sr0 = b_srdy_n;
      int waited = 0;
      b_drdy_en = 1'b0; b_saddr = 1'b0; b_sstep = 1'b1;
      tick();
      b_sstep = 1'b0;
      tick(249);
      checks++;
      if (b_err !== 1'b0) begin
         errors++; $display("FAIL timeout_early: got ERR=%b want 0", b_err);
      end
      for (waited = 0; waited < 10 && b_err !== 1'b1; waited++) tick();
      checks++;
      if (b_err !== 1'b1) begin
         errors++; $display("FAIL timeout_err: got ERR=%b want 1", b_err);
      end
      checks++;
      if (b_pll_rst !== 1'b0) begin
         errors++; $display("FAIL timeout_pll_rst: got %b want 0", b_pll_rst);
      end
      for (int i = 0; i < 50 && b_srdy_n == sr0; i++) tick();
      checks++;
      if (b_srdy_n != sr0 + 1 || b_ln - ln0 != 1 || b_lwe[ln0] !== 1'b0) begin
         errors++; $display("FAIL timeout_strobes: got srdy=%0d strobes=%0d want 1 1 read", b_srdy_n - sr0, b_ln - ln0);
      end
      checks++;
      if (b_err !== 1'b1) begin
         errors++; $display("FAIL timeout_sticky: got ERR=%b want 1", b_err);
      end
      b_drdy_en = 1'b1;
   endtask

   task automatic test_dyn_reconf;
      int ln0 = b_ln;
      int sr0 = b_srdy_n;
      int hi, lo, div, duty, phase;
      b_saddr = 1'b0; b_sstep = 1'b1;
      tick();
      b_sstep = 1'b0;
      checks++;
      if (b_err !== 1'b0) begin
         errors++; $display("FAIL err_clear: got ERR=%b want 0", b_err);
      end
      for (int i = 0; i < 100 && b_srdy_n == sr0; i++) tick();
      checks++;
      if (b_laddr[ln0+1] !== 7'h08 || b_lwe[ln0+1] !== 1'b1 || b_ldi[ln0+1] !== 16'h6183) begin
         errors++; $display("FAIL clkreg1_write: got addr=%h we=%b di=%h want 08 1 6183", b_laddr[ln0+1], b_lwe[ln0+1], b_ldi[ln0+1]);
      end
      hi    = int'(b_ldi[ln0+1][11:6]);
      lo    = int'(b_ldi[ln0+1][5:0]);
      div   = hi + lo;
      duty  = (div != 0) ? (hi * 1000) / div : 0;
      phase = int'(b_ldi[ln0+1][15:13]) * 32 / 8;
      checks++;
      if (div != 9 || duty != 666 || phase != 12) begin
         errors++; $display("FAIL clkout0_decode: got div=%0d duty=%0d phase=%0d want 9 666 12", div, duty, phase);
      end
   endtask

   task automatic test_busy_and_reset;
      int ln0 = b_ln;
      int sr0 = b_srdy_n;
      int n = 0;
      b_saddr = 1'b1; b_sstep = 1'b1;
      tick();
      b_sstep = 1'b0;
      for (n = 0; n < 50 && dut_b.state !== WAIT_W; n++) tick();
      b_saddr = 1'b0; b_sstep = 1'b1;
      tick();
      b_sstep = 1'b0;
      for (int i = 0; i < 100 && b_srdy_n == sr0; i++) tick();
      checks++;
      if (b_srdy_n != sr0 + 1 || b_ln - ln0 != 8 || b_ldi[ln0+7] !== 16'h3A3A || b_laddr[ln0+7] !== 7'h15) begin
         errors++; $display("FAIL sstep_ignored: got srdy=%0d strobes=%0d last=%h/%h want 1 8 15/3A3A",
            b_srdy_n - sr0, b_ln - ln0, b_laddr[ln0+7], b_ldi[ln0+7]);
      end
      tick(2);
      sr0 = b_srdy_n;
      b_sstep = 1'b1;
      tick();
      b_sstep = 1'b0;
      for (n = 0; n < 20 && dut_b.state !== WAIT_R; n++) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checks++;
      if (b_pll_rst !== 1'b0 || b_den !== 1'b0 || dut_b.state !== WAIT_LOCK) begin
         errors++; $display("FAIL rst_mid_seq: got pll_rst=%b den=%b state=%0d want 0 0 %0d", b_pll_rst, b_den, dut_b.state, WAIT_LOCK);
      end
      tick(20);
      checks++;
      if (b_srdy_n != sr0 || dut_b.state !== WAIT_SEN) begin
         errors++; $display("FAIL rst_no_srdy: got srdy=%0d state=%0d want 0 %0d", b_srdy_n - sr0, dut_b.state, WAIT_SEN);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         a_rdval[i] = 16'h0000;
         b_rdval[i] = 16'h0000;
      end
      a_rdval[8'h08] = 16'hA5C3;
      b_rdval[8'h08] = 16'h3456;
      b_rdval[8'h09] = 16'h1111;
      b_rdval[8'h14] = 16'h2222;
      b_rdval[8'h15] = 16'h3333;
      test_reset();
      test_single_rmw();
      test_set_select();
      test_timeout();
      test_dyn_reconf();
      test_busy_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
